// File: rtl/async_fifo_pkg.sv
// Shared defaults and pointer helpers for the circular-buffer FIFO.
package async_fifo_pkg;

  localparam int DEFAULT_RAM_WIDTH  = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // Wide enough for any practical pointer; callers truncate to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/async_fifo_sync2.sv
// Two-flop pointer synchronizer with a synchronous active-low clear.
module fifo_sync2 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/async_fifo.sv
// Circular-buffer FIFO whose pointers cross sides through Gray-coded
// synchronizers, so it can later be split across two clocks unchanged.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int RAM_WIDTH  = DEFAULT_RAM_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_rst,
  input  logic                 r_rst,
  input  logic                 w_req,
  input  logic [RAM_WIDTH-1:0] w_data,
  input  logic                 r_req,
  output logic [RAM_WIDTH-1:0] r_data,
  output logic                 w_full,
  output logic                 r_empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  logic                 w_clr_n, r_clr_n;
  logic                 w_en, r_en;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [RAM_WIDTH-1:0] r_data_q, r_data_d;
  logic [PW-1:0]        wgray, rgray;
  logic [PW-1:0]        wg_s2, rg_s2;
  logic [RAM_WIDTH-1:0] mem [DEPTH];

  assign w_clr_n = rst_n & w_rst;
  assign r_clr_n = rst_n & r_rst;

  assign w_en = w_req && !w_full;
  assign r_en = r_req && !r_empty;

  always_comb begin
    wptr_d   = wptr_q + PW'(w_en);
    rptr_d   = rptr_q + PW'(r_en);
    r_data_d = r_en ? mem[rptr_q[ADDR_WIDTH-1:0]] : r_data_q;
  end

  always_ff @(posedge clk) begin
    if (!w_clr_n) begin
      wptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
    end
  end

  // RAM contents survive every reset; only accepted writes touch them.
  always_ff @(posedge clk) begin
    if (w_clr_n && w_en) begin
      mem[wptr_q[ADDR_WIDTH-1:0]] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!r_clr_n) begin
      rptr_q   <= '0;
      r_data_q <= '0;
    end else begin
      rptr_q   <= rptr_d;
      r_data_q <= r_data_d;
    end
  end

  assign wgray = PW'(bin2gray(32'(wptr_q)));
  assign rgray = PW'(bin2gray(32'(rptr_q)));

  fifo_sync2 #(.WIDTH(PW)) u_wg_sync (
    .clk   (clk),
    .clr_n (r_clr_n),
    .d     (wgray),
    .q     (wg_s2)
  );

  fifo_sync2 #(.WIDTH(PW)) u_rg_sync (
    .clk   (clk),
    .clr_n (w_clr_n),
    .d     (rgray),
    .q     (rg_s2)
  );

  // Full when the write pointer is exactly one lap ahead of the synced read pointer.
  assign r_empty = (rgray == wg_s2);
  assign w_full  = (wgray == {~rg_s2[ADDR_WIDTH:ADDR_WIDTH-1], rg_s2[ADDR_WIDTH-2:0]});
  assign r_data  = r_data_q;

endmodule

// File: tb/tb_async_fifo.sv
// Directed and randomized checks of async_fifo against a pointer-arithmetic model.
module tb_async_fifo;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n, w_rst, r_rst, w_req, r_req;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data;
  logic          w_full, r_empty;

  int total = 0;
  int bad   = 0;

  // Model: free-running pointers, plus each pointer as the other side sees it
  // (two edges old), and an ordinary array for the storage.
  logic [AW:0]   mwp, mrp;
  logic [AW:0]   mws1, mws2;
  logic [AW:0]   mrs1, mrs2;
  logic [DW-1:0] mmem [1<<AW];
  logic [DW-1:0] mrdata;

  async_fifo #(.RAM_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .w_rst   (w_rst),
    .r_rst   (r_rst),
    .w_req   (w_req),
    .w_data  (w_data),
    .r_req   (r_req),
    .r_data  (r_data),
    .w_full  (w_full),
    .r_empty (r_empty)
  );

  always #5 clk = ~clk;

  function automatic logic modelFull();
    logic [AW:0] occ;
    occ = mwp - mrs2;
    return occ == (AW+1)'(1 << AW);
  endfunction

  function automatic logic modelEmpty();
    return mrp == mws2;
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [DW-1:0] wd, input logic rd,
                               input logic rn, input logic wc, input logic rc,
                               input string tag);
    logic [AW:0] owp, orp;
    logic        wacc, racc;
    w_req  = wr;
    w_data = wd;
    r_req  = rd;
    rst_n  = rn;
    w_rst  = wc;
    r_rst  = rc;
    wacc = wr && !modelFull();
    racc = rd && !modelEmpty();
    owp  = mwp;
    orp  = mrp;
    @(posedge clk);
    if (!(rn && rc)) begin
      mrp    = '0;
      mws1   = '0;
      mws2   = '0;
      mrdata = '0;
    end else begin
      if (racc) begin
        mrdata = mmem[orp[AW-1:0]];
        mrp    = orp + 1'b1;
      end
      mws2 = mws1;
      mws1 = owp;
    end
    if (!(rn && wc)) begin
      mwp  = '0;
      mrs1 = '0;
      mrs2 = '0;
    end else begin
      if (wacc) begin
        mmem[owp[AW-1:0]] = wd;
        mwp = owp + 1'b1;
      end
      mrs2 = mrs1;
      mrs1 = orp;
    end
    #1;
    checkOutput({tag, " r_data"}, r_data, mrdata);
    checkOutput({tag, " r_empty"}, DW'(r_empty), DW'(modelEmpty()));
    checkOutput({tag, " w_full"}, DW'(w_full), DW'(modelFull()));
  endtask

  initial begin
    logic [DW-1:0] cval;
    for (int i = 0; i < (1 << AW); i++) mmem[i] = 'x;
    mwp = '0; mrp = '0; mws1 = '0; mws2 = '0; mrs1 = '0; mrs2 = '0; mrdata = '0;
    rst_n = 1'b1; w_rst = 1'b1; r_rst = 1'b1; w_req = 1'b0; r_req = 1'b0; w_data = '0;
    $display("[TB] starting async_fifo checks");

    // Reset state
    applyStimulus(0, 8'h00, 0, 0, 1, 1, "reset");
    checkOutput("reset empty", DW'(r_empty), 8'd1);
    checkOutput("reset full", DW'(w_full), 8'd0);
    checkOutput("reset data", r_data, 8'd0);

    // Fill past capacity; the last two writes must be dropped
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1, DW'(i), 0, 1, 1, 1, "fill");
      if (i == 15) checkOutput("fill full@16", DW'(w_full), 8'd1);
    end
    checkOutput("fill empty", DW'(r_empty), 8'd0);

    // Drain more than was stored; data holds on the empty reads
    for (int i = 0; i < 18; i++) begin
      applyStimulus(0, 8'h00, 1, 1, 1, 1, "drain");
      checkOutput("drain value", r_data, (i < 16) ? DW'(i) : 8'd15);
      if (i == 15) checkOutput("drain empty@16", DW'(r_empty), 8'd1);
    end

    // Full release takes two edges after a read
    applyStimulus(0, 8'h00, 0, 0, 1, 1, "reset2");
    for (int i = 0; i < 16; i++) applyStimulus(1, DW'(i), 0, 1, 1, 1, "refill");
    checkOutput("refill full", DW'(w_full), 8'd1);
    applyStimulus(0, 8'h00, 1, 1, 1, 1, "release rd");
    checkOutput("release data", r_data, 8'd0);
    checkOutput("release full+0", DW'(w_full), 8'd1);
    applyStimulus(0, 8'h00, 0, 1, 1, 1, "release idle1");
    checkOutput("release full+1", DW'(w_full), 8'd1);
    applyStimulus(0, 8'h00, 0, 1, 1, 1, "release idle2");
    checkOutput("release full+2", DW'(w_full), 8'd0);
    applyStimulus(1, 8'hAA, 0, 1, 1, 1, "release wr");
    checkOutput("release refull", DW'(w_full), 8'd1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 8'h00, 1, 1, 1, 1, "release drain");
      checkOutput("release order", r_data, (i < 15) ? DW'(i + 1) : 8'hAA);
    end

    // Concurrent read and write at constant occupancy, wrapping the pointers
    applyStimulus(0, 8'h00, 0, 0, 1, 1, "reset3");
    for (int i = 0; i < 5; i++) applyStimulus(1, DW'($urandom), 0, 1, 1, 1, "prefill");
    applyStimulus(0, 8'h00, 0, 1, 1, 1, "settle");
    applyStimulus(0, 8'h00, 0, 1, 1, 1, "settle");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, DW'($urandom), 1, 1, 1, 1, "concurrent");
      checkOutput("concurrent empty", DW'(r_empty), 8'd0);
      checkOutput("concurrent full", DW'(w_full), 8'd0);
    end

    // Read-side clear with eight entries queued
    applyStimulus(0, 8'h00, 0, 0, 1, 1, "reset4");
    for (int i = 0; i < 8; i++) applyStimulus(1, 8'h40 + DW'(i), 0, 1, 1, 1, "sc fill");
    applyStimulus(0, 8'h00, 0, 1, 1, 1, "sc settle");
    applyStimulus(0, 8'h00, 0, 1, 1, 1, "sc settle");
    applyStimulus(0, 8'h00, 0, 1, 1, 0, "sc clear");
    checkOutput("sc data", r_data, 8'd0);
    checkOutput("sc empty", DW'(r_empty), 8'd1);
    applyStimulus(0, 8'h00, 0, 1, 1, 1, "sc resync1");
    applyStimulus(0, 8'h00, 0, 1, 1, 1, "sc resync2");
    checkOutput("sc resynced", DW'(r_empty), 8'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 8'h00, 1, 1, 1, 1, "sc read");
      cval = 8'h40 + DW'(i);
      checkOutput("sc stale", r_data, cval);
    end

    // Random traffic with occasional resets of either side
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom), DW'($urandom), 1'($urandom),
                    ($urandom_range(99) != 0), ($urandom_range(79) != 0),
                    ($urandom_range(79) != 0), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
